// File: rtl/bypass_bin_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bypass_bin_encoder
// Purpose  : CABAC bypass-bin arithmetic encoder with outstanding-byte carry
//            resolution, back-pressured byte output and end-of-stream flush.
// Revision : 1.0  initial release
// ============================================================================
module bypass_bin_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       bin_valid,
  input  logic       bin,
  input  logic [8:0] range_in,
  output logic       bin_ready,
  input  logic       flush,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_EMIT       = 3'd1,
    ST_EMIT_RUN   = 3'd2,
    ST_FLUSH_HEAD = 3'd3,
    ST_FLUSH_RUN  = 3'd4,
    ST_FLUSH_TAIL = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  localparam logic [4:0] c_BITS_LEFT_INIT = 5'd23;
  localparam logic [7:0] c_BUF_BYTE_INIT  = 8'hFF;

  state_t      r_state, w_state_nx;
  logic [31:0] r_low, w_low_nx;
  logic [4:0]  r_bits_left, w_bits_left_nx;
  logic [7:0]  r_buffered_byte, w_buffered_byte_nx;
  logic [7:0]  r_num_buffered, w_num_buffered_nx;
  logic [7:0]  r_emit_byte, w_emit_byte_nx;
  logic        r_carry, w_carry_nx;
  logic        r_tail_idx, w_tail_idx_nx;

  logic [31:0] w_low_upd;
  logic [4:0]  w_bits_dec;
  logic [4:0]  w_bits_wo;
  logic [8:0]  w_lead;
  logic [5:0]  w_head_shift;
  logic        w_head_carry;
  logic [15:0] w_tail;
  logic        w_tail_two;
  logic [7:0]  w_num_inc;
  logic [7:0]  w_run_byte;

  assign w_low_upd    = (r_low << 1) + (bin ? {23'd0, range_in} : 32'd0);
  assign w_bits_dec   = r_bits_left - 5'd1;
  assign w_bits_wo    = w_bits_dec + 5'd8;
  assign w_lead       = 9'(w_low_upd >> (5'd24 - w_bits_dec));
  assign w_head_shift = 6'd32 - {1'b0, r_bits_left};
  assign w_head_carry = (r_low >> w_head_shift) != 32'd0;
  // Remaining low[31-bits_left:8] pushed to the top so it reads out left-aligned.
  assign w_tail       = 16'(((r_low >> 8) << ({1'b0, r_bits_left} + 6'd8)) >> 16);
  assign w_tail_two   = r_bits_left < 5'd16;
  assign w_num_inc    = (r_num_buffered == 8'hFF) ? 8'hFF : r_num_buffered + 8'd1;
  assign w_run_byte   = r_carry ? 8'h00 : 8'hFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_low           <= 32'd0;
      r_bits_left     <= c_BITS_LEFT_INIT;
      r_buffered_byte <= c_BUF_BYTE_INIT;
      r_num_buffered  <= 8'd0;
      r_emit_byte     <= 8'd0;
      r_carry         <= 1'b0;
      r_tail_idx      <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_low           <= w_low_nx;
      r_bits_left     <= w_bits_left_nx;
      r_buffered_byte <= w_buffered_byte_nx;
      r_num_buffered  <= w_num_buffered_nx;
      r_emit_byte     <= w_emit_byte_nx;
      r_carry         <= w_carry_nx;
      r_tail_idx      <= w_tail_idx_nx;
    end
  end

  always_comb begin
    w_state_nx         = r_state;
    w_low_nx           = r_low;
    w_bits_left_nx     = r_bits_left;
    w_buffered_byte_nx = r_buffered_byte;
    w_num_buffered_nx  = r_num_buffered;
    w_emit_byte_nx     = r_emit_byte;
    w_carry_nx         = r_carry;
    w_tail_idx_nx      = r_tail_idx;
    bin_ready          = 1'b0;
    byte_valid         = 1'b0;
    byte_out           = 8'h00;
    done               = 1'b0;

    case (r_state)
      ST_IDLE: begin
        bin_ready = 1'b1;
        if (bin_valid) begin
          w_low_nx       = w_low_upd;
          w_bits_left_nx = w_bits_dec;
          if (w_bits_dec < 5'd12) begin
            w_bits_left_nx = w_bits_wo;
            w_low_nx       = w_low_upd & (32'hFFFF_FFFF >> w_bits_wo);
            if (w_lead == 9'h0FF) begin
              w_num_buffered_nx = w_num_inc;
            end else if (r_num_buffered == 8'd0) begin
              w_buffered_byte_nx = w_lead[7:0];
              w_num_buffered_nx  = 8'd1;
            end else begin
              // The held byte absorbs the carry; the new lead takes its place.
              w_carry_nx         = w_lead[8];
              w_emit_byte_nx     = r_buffered_byte + {7'd0, w_lead[8]};
              w_buffered_byte_nx = w_lead[7:0];
              w_state_nx         = ST_EMIT;
            end
          end
        end else if (flush) begin
          w_tail_idx_nx = 1'b0;
          w_carry_nx    = w_head_carry;
          if (w_head_carry) begin
            w_low_nx   = r_low - (32'd1 << w_head_shift);
            w_state_nx = ST_FLUSH_HEAD;
          end else begin
            w_state_nx = (r_num_buffered != 8'd0) ? ST_FLUSH_HEAD : ST_FLUSH_TAIL;
          end
        end
      end

      ST_EMIT: begin
        byte_valid = 1'b1;
        byte_out   = r_emit_byte;
        if (byte_ready) begin
          w_state_nx = (r_num_buffered > 8'd1) ? ST_EMIT_RUN : ST_IDLE;
        end
      end

      ST_EMIT_RUN: begin
        byte_valid = 1'b1;
        byte_out   = w_run_byte;
        if (byte_ready) begin
          w_num_buffered_nx = r_num_buffered - 8'd1;
          if (r_num_buffered <= 8'd2) w_state_nx = ST_IDLE;
        end
      end

      ST_FLUSH_HEAD: begin
        byte_valid = 1'b1;
        byte_out   = r_buffered_byte + {7'd0, r_carry};
        if (byte_ready) begin
          w_state_nx = (r_num_buffered > 8'd1) ? ST_FLUSH_RUN : ST_FLUSH_TAIL;
        end
      end

      ST_FLUSH_RUN: begin
        byte_valid = 1'b1;
        byte_out   = w_run_byte;
        if (byte_ready) begin
          w_num_buffered_nx = r_num_buffered - 8'd1;
          if (r_num_buffered <= 8'd2) w_state_nx = ST_FLUSH_TAIL;
        end
      end

      ST_FLUSH_TAIL: begin
        byte_valid = 1'b1;
        byte_out   = r_tail_idx ? w_tail[7:0] : w_tail[15:8];
        if (byte_ready) begin
          if (!r_tail_idx && w_tail_two) w_tail_idx_nx = 1'b1;
          else                           w_state_nx    = ST_DONE;
        end
      end

      ST_DONE: begin
        done = 1'b1;
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
